// File: rtl/l2_cache_control.sv
// L2 cache controller: sequences tag check, dirty writeback, line allocate and
// refill recheck for a 2-way write-back cache; keeps saturating perf counters.
module l2_cache_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    input  logic             hit0,
    input  logic             hit1,
    input  logic             dirty0,
    input  logic             dirty1,
    input  logic             lru,
    output logic             way_sel,
    output logic [1:0]       load_data,
    output logic             data_in_sel,
    output logic             load_meta,
    output logic             dirty_in,
    output logic             load_lru,
    output logic             lru_in,
    output logic             pmem_addr_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [2:0] {
        IDLE, TAG_CHECK, WRITEBACK, ALLOCATE, REFILL_WAIT
    } state_t;

    state_t state;
    logic   refilled;
    logic   victim;

    logic req, is_wr, hit, hit_way, victim_dirty;
    assign req          = mem_read | mem_write;
    assign is_wr        = mem_write;
    assign hit          = hit0 | hit1;
    assign hit_way      = ~hit0;             // way0 wins when both match
    assign victim_dirty = lru ? dirty1 : dirty0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            refilled   <= 1'b0;
            victim     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= TAG_CHECK;
                        refilled <= 1'b0;
                    end
                end
                TAG_CHECK: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (hit) begin
                        // the post-refill recheck is not a real hit
                        if (!refilled && hit_count != '1) hit_count <= hit_count + 1'b1;
                        state <= IDLE;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        victim <= lru;
                        state  <= victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        if (wb_count != '1) wb_count <= wb_count + 1'b1;
                        state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        refilled <= 1'b1;
                        state    <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: state <= TAG_CHECK;
                default:     state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        way_sel       = 1'b0;
        load_data     = 2'b00;
        data_in_sel   = 1'b0;
        load_meta     = 1'b0;
        dirty_in      = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        pmem_addr_sel = 1'b0;
        case (state)
            TAG_CHECK: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    lru_in   = ~hit_way;
                    way_sel  = hit_way;
                    if (is_wr) begin
                        load_data = hit_way ? 2'b10 : 2'b01;
                        load_meta = 1'b1;
                        dirty_in  = 1'b1;
                    end
                end else if (req) begin
                    way_sel = lru;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = victim;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = victim;
                if (pmem_resp) begin
                    load_data   = victim ? 2'b10 : 2'b01;
                    data_in_sel = 1'b1;
                    load_meta   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l2_cache_control.sv
// Self-checking bench for l2_cache_control: directed scenarios plus random
// transactions checked against a transaction-level expectation model.
module tb_l2_cache_control;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
    logic hit0, hit1, dirty0, dirty1, lru, way_sel;
    logic [1:0] load_data;
    logic data_in_sel, load_meta, dirty_in, load_lru, lru_in, pmem_addr_sel;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    int total = 0;
    int bad   = 0;
    int e_hit = 0, e_miss = 0, e_wb = 0;

    always #5 clk = ~clk;

    l2_cache_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1), .lru(lru),
        .way_sel(way_sel), .load_data(load_data), .data_in_sel(data_in_sel),
        .load_meta(load_meta), .dirty_in(dirty_in), .load_lru(load_lru),
        .lru_in(lru_in), .pmem_addr_sel(pmem_addr_sel),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    // {mem_resp, pmem_read, pmem_write, way_sel, load_data, data_in_sel,
    //  load_meta, dirty_in, load_lru, lru_in, pmem_addr_sel}
    wire [11:0] outs = {mem_resp, pmem_read, pmem_write, way_sel, load_data,
                        data_in_sel, load_meta, dirty_in, load_lru, lru_in, pmem_addr_sel};

    function automatic logic [11:0] pk(input logic mr, pr, pw, ws, input logic [1:0] ld,
                                       input logic dis, lm, di, ll, li, pas);
        return {mr, pr, pw, ws, ld, dis, lm, di, ll, li, pas};
    endfunction

    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    function automatic int sat(input int v);
        return (v >= MAX) ? MAX : v + 1;
    endfunction

    // One full upstream transaction; the bench plays the datapath, reporting
    // a hit on the refilled way at the recheck.
    task automatic run_txn(input bit wr, input bit both, input bit h0, input bit h1,
                           input bit d0, input bit d1, input bit l, input int dly,
                           input bit stray);
        bit hw, wb_need;
        logic [11:0] exp;
        hw      = h0 ? 1'b0 : 1'b1;
        wb_need = l ? d1 : d0;
        @(negedge clk);
        mem_write = wr; mem_read = !wr | both;
        hit0 = h0; hit1 = h1; dirty0 = d0; dirty1 = d1; lru = l; pmem_resp = 1'b0;
        #1;
        total++;
        if (outs !== 12'h0) begin bad++; $display("FAIL idle_outs got=%h exp=%h", outs, 12'h0); end
        @(negedge clk);
        pmem_resp = stray;
        #1;
        if (h0 | h1) begin
            exp = pk(1, 0, 0, hw, wr ? onehot(hw) : 2'b00, 0, wr, wr, 1, ~hw, 0);
            e_hit = sat(e_hit);
            total++;
            if (outs !== exp) begin bad++; $display("FAIL tag_hit got=%h exp=%h", outs, exp); end
        end else begin
            exp = pk(0, 0, 0, l, 2'b00, 0, 0, 0, 0, 0, 0);
            e_miss = sat(e_miss);
            total++;
            if (outs !== exp) begin bad++; $display("FAIL tag_miss got=%h exp=%h", outs, exp); end
            if (wb_need) begin
                for (int k = 0; k < dly; k++) begin
                    @(negedge clk);
                    pmem_resp = (k == dly - 1);
                    lru = 1'($urandom);
                    #1;
                    exp = pk(0, 0, 1, l, 2'b00, 0, 0, 0, 0, 0, 1);
                    total++;
                    if (outs !== exp) begin bad++; $display("FAIL writeback k=%0d got=%h exp=%h", k, outs, exp); end
                end
                e_wb = sat(e_wb);
            end
            for (int k = 0; k < dly; k++) begin
                bit last;
                last = (k == dly - 1);
                @(negedge clk);
                pmem_resp = last;
                lru = 1'($urandom);
                #1;
                exp = pk(0, 1, 0, l, last ? onehot(l) : 2'b00, last, last, 0, 0, 0, 0);
                total++;
                if (outs !== exp) begin bad++; $display("FAIL allocate k=%0d got=%h exp=%h", k, outs, exp); end
            end
            @(negedge clk);
            pmem_resp = 1'b0;
            hit0 = (l == 1'b0); hit1 = (l == 1'b1);
            #1;
            total++;
            if (outs !== 12'h0) begin bad++; $display("FAIL refill_wait got=%h exp=%h", outs, 12'h0); end
            @(negedge clk);
            #1;
            exp = pk(1, 0, 0, l, wr ? onehot(l) : 2'b00, 0, wr, wr, 1, ~l, 0);
            total++;
            if (outs !== exp) begin bad++; $display("FAIL recheck got=%h exp=%h", outs, exp); end
        end
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        #1;
        total++;
        if (outs !== 12'h0) begin bad++; $display("FAIL post_idle got=%h exp=%h", outs, 12'h0); end
        total++;
        if ({hit_count, miss_count, wb_count} !== {CW'(e_hit), CW'(e_miss), CW'(e_wb)}) begin
            bad++;
            $display("FAIL counts got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     hit_count, miss_count, wb_count, e_hit, e_miss, e_wb);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        e_hit = 0; e_miss = 0; e_wb = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        hit0 = 0; hit1 = 0; dirty0 = 0; dirty1 = 0; lru = 0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (outs !== 12'h0) begin bad++; $display("FAIL reset_outs got=%h exp=%h", outs, 12'h0); end
        total++;
        if ({hit_count, miss_count, wb_count} !== '0) begin
            bad++; $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", hit_count, miss_count, wb_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; hit0 = 0; hit1 = 0; dirty0 = 0; dirty1 = 0; lru = 0;
        @(negedge clk);           // TAG_CHECK, clean miss
        @(negedge clk);           // ALLOCATE
        #1;
        total++;
        if (pmem_read !== 1'b1) begin bad++; $display("FAIL mid_alloc_pmem_read got=%b exp=1", pmem_read); end
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (outs !== 12'h0) begin bad++; $display("FAIL mid_reset_outs got=%h exp=%h", outs, 12'h0); end
        total++;
        if ({hit_count, miss_count, wb_count} !== '0) begin
            bad++; $display("FAIL mid_reset_counts got=%0d/%0d/%0d exp=0/0/0", hit_count, miss_count, wb_count);
        end
        rst = 1'b0;
        e_hit = 0; e_miss = 0; e_wb = 0;
        run_txn(0, 0, 1, 0, 0, 0, 1, 1, 0);
    endtask

    task automatic test_read_hit();
        run_txn(0, 0, 0, 1, 0, 0, 1, 1, 0);
    endtask

    task automatic test_dirty_write_miss();
        run_txn(1, 0, 0, 0, 1, 0, 0, 3, 0);
        total++;
        if (hit_count !== CW'(e_hit)) begin bad++; $display("FAIL dwm_hit got=%0d exp=%0d", hit_count, e_hit); end
    endtask

    task automatic test_clean_miss_latency();
        run_txn(0, 0, 0, 0, 1, 0, 1, 10, 0);
    endtask

    task automatic test_dual_hit_and_drop();
        int h, m, w;
        run_txn(1, 1, 1, 1, 0, 0, 1, 1, 0);
        h = e_hit; m = e_miss; w = e_wb;
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; hit0 = 1; hit1 = 0;
        @(negedge clk);
        mem_read = 1'b0;          // dropped while in TAG_CHECK
        #1;
        total++;
        if (outs !== 12'h0) begin bad++; $display("FAIL drop_outs got=%h exp=%h", outs, 12'h0); end
        @(negedge clk);
        #1;
        total++;
        if ({hit_count, miss_count, wb_count} !== {CW'(h), CW'(m), CW'(w)}) begin
            bad++; $display("FAIL drop_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                            hit_count, miss_count, wb_count, h, m, w);
        end
        run_txn(0, 0, 0, 1, 0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit wr, h0, h1;
            wr = 1'($urandom);
            h0 = ($urandom_range(0, 2) == 0);
            h1 = ($urandom_range(0, 2) == 0);
            run_txn(wr, 1'($urandom), h0, h1, 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(1, 6), 1'($urandom));
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < MAX + 2; i++) run_txn(0, 0, 1, 0, 0, 0, 0, 1, 0);
        total++;
        if (hit_count !== CW'(MAX)) begin bad++; $display("FAIL hit_saturate got=%0d exp=%0d", hit_count, MAX); end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_dirty_write_miss();
        test_clean_miss_latency();
        test_dual_hit_and_drop();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_cache_control.md
Name: l2_cache_control

Overview:
- FSM that sequences the L2 cache datapath (2-way set-associative, 256-bit lines, write-back, write-allocate).
- Sits between the L1 miss arbiter (mem_* side) and physical memory (pmem_* side).
- Consumes hit/dirty/LRU status from the L2 datapath; drives array load enables, way and mux selects, and the pmem handshake.
- Keeps saturating hit/miss/writeback performance counters.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
mem_read  in  1  upstream line read request; held until mem_resp
mem_write  in  1  upstream line write request; held until mem_resp
mem_resp  out  1  one-cycle completion pulse to upstream
pmem_read  out  1  physical memory line read
pmem_write  out  1  physical memory line write
pmem_resp  in  1  physical memory completion pulse
hit0  in  1  way0 valid and tag match for current address (datapath, combinational)
hit1  in  1  way1 valid and tag match
dirty0  in  1  way0 dirty bit of indexed set
dirty1  in  1  way1 dirty bit of indexed set
lru  in  1  replacement way of indexed set
way_sel  out  1  way addressed by data/meta writes and the writeback read
load_data  out  2  per-way data array write enable
data_in_sel  out  1  0 = mem_wdata, 1 = pmem_rdata
load_meta  out  1  write tag, valid=1, dirty=dirty_in into way_sel
dirty_in  out  1  dirty value written with load_meta
load_lru  out  1  write lru_in to indexed set
lru_in  out  1  new LRU value (the way not just used)
pmem_addr_sel  out  1  0 = request address, 1 = {victim tag, index, 5'b0}
hit_count  out  CNT_W  requests that hit on first tag check
miss_count  out  CNT_W  requests that missed
wb_count  out  CNT_W  completed dirty writebacks

Behaviour:
- States: IDLE, TAG_CHECK, WRITEBACK, ALLOCATE, REFILL_WAIT.
- rst: state IDLE, refilled flag 0, all counters 0. All outputs deassert the cycle after rst is sampled, including mid-WRITEBACK/ALLOCATE; any in-flight pmem transaction is abandoned.
- Outputs are combinational from state and inputs. Defaults are 0 and are driven only in the cases below.
- IDLE: mem_read or mem_write -> TAG_CHECK; refilled cleared. Arrays have 1-cycle synchronous read, so status is valid in TAG_CHECK.
- TAG_CHECK, request dropped: -> IDLE with no array writes, no counter change.
- TAG_CHECK, hit (hit0 or hit1; if both, way0 wins):
  - mem_resp=1; load_lru=1; lru_in=~hitway; way_sel=hitway.
  - If write: load_data[hitway]=1, data_in_sel=0, load_meta=1, dirty_in=1.
  - hit_count increments only if refilled=0. Next state IDLE.
- TAG_CHECK, miss: miss_count increments; way_sel=lru.
  - If dirty of the lru way is set -> WRITEBACK, else -> ALLOCATE.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_sel=lru (latched at miss). On pmem_resp: wb_count increments -> ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_addr_sel=0, way_sel=lru. On pmem_resp:
  - load_data[lru]=1, data_in_sel=1, load_meta=1, dirty_in=0; set refilled=1 -> REFILL_WAIT.
- REFILL_WAIT: no outputs; -> TAG_CHECK. The recheck hits; a write merges there, which sets dirty.
- Victim way is latched into a register on leaving TAG_CHECK. lru changes during the miss are ignored.
- pmem_read/pmem_write stay asserted until pmem_resp. pmem_resp in any other state is ignored.
- mem_read and mem_write both high: treated as write.
- Latency, request at cycle 0:
  - Hit: mem_resp at cycle 1.
  - Clean miss: mem_resp 2 cycles after pmem_resp.
- Counters saturate at all-ones and do not wrap.

Test Plan:
- rst mid-ALLOCATE with pmem_read=1 -> next cycle pmem_read=0, state IDLE, all counts 0; subsequent request proceeds normally.
- Read, hit1=1, lru=1 -> mem_resp at cycle 1, load_lru=1, lru_in=0, load_data=00, hit_count=1.
- Write, miss, lru=0, dirty0=1 -> WRITEBACK (pmem_write, addr_sel=1, way_sel=0) until pmem_resp. Then ALLOCATE; then load_data=01, load_meta, dirty_in=0. Then REFILL_WAIT; then TAG_CHECK hit0, load_data=01, data_in_sel=0, dirty_in=1, mem_resp. Counts: miss=1, wb=1, hit=0.
- Read, clean miss, lru=1, pmem_resp after 10 cycles -> no pmem_write; load_data=10 on resp cycle; mem_resp exactly 2 cycles later.
- Force hit_count to 2^CNT_W-1 (CNT_W=4, 15 hits), then one more hit -> stays 15.
- hit0=hit1=1 on write; then mem_read dropped in TAG_CHECK -> write goes to way0 only. Dropped request: IDLE, no mem_resp, no array or counter change.
